multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Top-level sequencer for the multi-cycle LEGv8 datapath.
- Fetches each instruction into the instruction register (IR) and drives the 2-bit micro-state into the format decoders.
- Passes the selected decoder's 33-bit control word to the datapath, gating it while data RAM is not ready.
- Counts stall cycles and enters a sticky fault state on memory timeout.

Parameters:
- CW_WIDTH, 33, control word width; field layout fixed, see Behaviour.
- STALL_LIMIT, 15, max consecutive data-RAM stall cycles before fault (1..255).
- CNT_WIDTH, 8, stall counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_in  input  32  instruction word from instruction memory.
- instr_valid  input  1  instr_in valid this cycle.
- mem_ready  input  1  data RAM completes the current access this cycle.
- cw_exec  input  33  control word from the decoder mux for current IR/state.
- fetch_req  output  1  instruction fetch request.
- ir  output  32  instruction register, feeds the decoders.
- state  output  2  micro-state, feeds the decoders.
- cw_out  output  33  control word to the datapath.
- stalled  output  1  EXEC cycle held waiting on mem_ready.
- fault  output  1  sticky memory-timeout fault.

Behaviour:
- Control word fields:
  - [32] alu_en, [31] alu_bs, [30:26] alu_fs, [25] rf_b_en
  - [24:20] rf_sa, [19:15] rf_sb, [14:10] rf_da, [9] rf_w
  - [8] ram_en, [7] ram_w, [6] pc_en, [5:4] pc_fs, [3] pc_is
  - [2] status_ld, [1:0] next_state
- Phase FSM: FETCH, EXEC, FAULT. Phase, ir, state and stall_cnt are registered; cw_out, fetch_req and stalled are combinational from the registers and inputs.
- Reset (asynchronous, any time, including mid-instruction or in FAULT):
  - phase=FETCH, ir=0, state=0, stall_cnt=0, fault=0.
  - While reset is held: cw_out=0 (pc_fs=00 hold, all writes off), fetch_req=1, stalled=0.
- FETCH:
  - fetch_req=1; cw_out=all zero.
  - On instr_valid=1: ir<=instr_in, state<=0, phase<=EXEC. Otherwise hold.
- EXEC:
  - fetch_req=0.
  - mem_access = cw_exec[8] | cw_exec[7].
  - Stall condition: mem_access=1 and mem_ready=0.
  - During a stall:
    - stalled=1.
    - cw_out=cw_exec with rf_w, pc_en and status_ld forced 0 and pc_fs forced 00.
    - ram_en and ram_w pass through, so the request stays asserted.
    - state and ir hold; stall_cnt increments.
  - Not stalled (no mem access, or mem_ready=1):
    - cw_out=cw_exec unmodified; stall_cnt<=0.
    - If next_state (cw_exec[1:0])=00: state<=0, phase<=FETCH. The PC update in this cycle is the decoder's responsibility.
    - Otherwise state<=next_state and phase stays EXEC.
  - Timeout: a stall cycle with stall_cnt=STALL_LIMIT-1 goes to phase<=FAULT, fault<=1. That is, STALL_LIMIT stall cycles trigger the fault.
  - mem_ready=1 in the same cycle as the limit is reached: completion wins, no fault.
- FAULT:
  - cw_out=0, fetch_req=0, fault=1.
  - Held until reset; all inputs are ignored.
- mem_ready and instr_valid are ignored outside their own phases.
- ir changes only on a FETCH acceptance. A multi-state instruction sees a stable ir throughout.
- cw_exec is not registered, so there is zero added latency from decoder to datapath.
- Minimum instruction time: 1 FETCH cycle plus 1 EXEC cycle per micro-state.

Test Plan:
- Reset, then instr_valid=1 with instr_in=0xF8408020 (LDUR) and cw_exec next_state=00, ram_en=1, mem_ready=1:
  - Cycle 1: fetch_req=1.
  - Cycle 2: ir=0xF8408020, cw_out==cw_exec, stalled=0.
  - Cycle 3: back in FETCH, fetch_req=1.
- Same load with mem_ready low for 3 cycles:
  - stalled=1 for 3 cycles; cw_out rf_w=0 and pc_fs=00, ram_en=1.
  - 4th cycle: full cw_exec passes, then FETCH.
- Multi-state instruction, cw_exec next_state sequence 01, 10, 00, no memory:
  - state output steps 0→1→2.
  - FETCH follows the third EXEC cycle; ir is constant throughout.
- Store (ram_w=1) with mem_ready held 0, STALL_LIMIT=15:
  - fault=1 after exactly 15 stall cycles; cw_out=0 thereafter.
  - instr_valid is ignored; reset clears fault and returns to FETCH.
- mem_ready=1 on the 15th stall cycle → no fault; instruction completes.
- Reset asserted asynchronously mid-EXEC (state=1) between clock edges:
  - state=0, ir=0, cw_out=0 and fetch_req=1 immediately, without waiting for a clock edge.
  - Normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multi-cycle LEGv8 datapath: fetches into ir, steps the
// micro-state and forwards the decoder control word, holding side effects while data RAM stalls.
`timescale 1ns/1ps
module multicycle_sequencer #(
  parameter int CW_WIDTH    = 33,
  parameter int STALL_LIMIT = 15,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         instr_in,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic [CW_WIDTH-1:0] cw_exec,
  output logic                fetch_req,
  output logic [31:0]         ir,
  output logic [1:0]          state,
  output logic [CW_WIDTH-1:0] cw_out,
  output logic                stalled,
  output logic                fault
);

  typedef enum logic [1:0] {FETCH, EXEC, FAULT} phase_t;

  // Fields silenced while stalled: rf_w, pc_en, pc_fs and status_ld.
  localparam logic [CW_WIDTH-1:0] STALL_MASK = CW_WIDTH'(33'h0_0000_0274);
  localparam logic [CNT_WIDTH-1:0] LAST_STALL = CNT_WIDTH'(STALL_LIMIT - 1);

  phase_t               phase;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic                 mem_access;
  logic                 stall_cond;

  assign mem_access = cw_exec[8] | cw_exec[7];
  assign stall_cond = mem_access & ~mem_ready;

  always_comb begin
    fetch_req = 1'b0;
    cw_out    = '0;
    stalled   = 1'b0;
    case (phase)
      FETCH: fetch_req = 1'b1;
      EXEC: begin
        if (stall_cond) begin
          stalled = 1'b1;
          cw_out  = cw_exec & ~STALL_MASK;
        end else begin
          cw_out = cw_exec;
        end
      end
      default: ;
    endcase
  end

  // Completion beats timeout: the limit test only applies on a genuine stall cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase     <= FETCH;
      ir        <= '0;
      state     <= '0;
      stall_cnt <= '0;
      fault     <= 1'b0;
    end else begin
      case (phase)
        FETCH: begin
          if (instr_valid) begin
            ir        <= instr_in;
            state     <= '0;
            stall_cnt <= '0;
            phase     <= EXEC;
          end
        end
        EXEC: begin
          if (stall_cond) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            if (stall_cnt == LAST_STALL) begin
              phase <= FAULT;
              fault <= 1'b1;
            end
          end else begin
            stall_cnt <= '0;
            if (cw_exec[1:0] == 2'b00) begin
              state <= '0;
              phase <= FETCH;
            end else begin
              state <= cw_exec[1:0];
            end
          end
        end
        FAULT: fault <= 1'b1;
        default: phase <= FETCH;
      endcase
    end
  end

endmodule
